rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Eight-way round-robin arbiter that shares one downstream resource among eight requesters and presents the winner both as a 3-bit index and as a one-hot grant vector. The one-hot grant comes from the team's existing `decoder_3X8`. An optional hold limit forces rotation when a requester keeps the grant while others wait.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive GRANT cycles before forced release when another request is pending. 0 disables the limit.
- `clk`, in, 1: single clock, all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 8: level requests; `req[i]` stays high until requester i is done.
- `grant`, out, 8: one-hot grant, all zero when no grant is active.
- `grant_idx`, out, 3: index of the current or most recent winner.
- `grant_valid`, out, 1: high while a grant is active.
- `timeout`, out, 1: one-cycle pulse on a forced release.

## Operation
- The FSM has two states, IDLE and GRANT.
- Reset values: state=IDLE, `grant`=8'h00, `grant_idx`=3'd0, `grant_valid`=0, `timeout`=0, `last_idx`=3'd7 (so the first search starts at requester 0), hold counter=0.
- IDLE:
  - If `req` != 0, pick the first set bit searching upward from `last_idx`+1, modulo 8 with wrap 7->0.
  - Load `grant_idx`, set `grant_valid`=1, clear the hold counter, and go to GRANT.
  - If `req`=0, stay in IDLE.
- GRANT, normal release: if `req[grant_idx]`=0, clear `grant_valid`, set `last_idx`=`grant_idx`, and go to IDLE.
- GRANT, forced release: if `MAX_HOLD`!=0, the hold counter = `MAX_HOLD`-1, `req[grant_idx]`=1, and any other `req` bit is 1:
  - Pulse `timeout` for one cycle.
  - Clear `grant_valid`, set `last_idx`=`grant_idx`, and go to IDLE.
- GRANT, hold limit reached with no other request pending: the counter saturates at `MAX_HOLD`-1 and the grant is kept, with no timeout.
- GRANT, otherwise: increment the hold counter and stay in GRANT.
- Request changes during GRANT:
  - New requests are ignored until the next IDLE cycle.
  - A non-granted requester that drops its request before IDLE is simply not selected.
- `grant` = `decoder_3X8({x,y,z}=grant_idx)` AND {8{`grant_valid`}}. It is never more than one-hot.
- Hold counter width is $clog2(`MAX_HOLD`+1), with a minimum of 1 bit.

## Timing
- Arbitration latency: a `req` sampled in IDLE at edge N produces `grant_valid`/`grant` after edge N.
- Release: a `req[grant_idx]` drop sampled at edge N gives `grant`=0 after edge N. The next grant comes no earlier than after edge N+1.
- Every grant handover therefore has exactly one idle cycle with `grant_valid`=0.
- Forced release: `timeout` and `grant_valid`=0 appear together after the edge at which the counter equals `MAX_HOLD`-1. The grant lasts exactly `MAX_HOLD` cycles.
- Reset mid-grant: `rst_n` low clears all outputs immediately, without waiting for `clk`, and restores reset values. After release, the search restarts at index 0.
- `grant_idx` holds its last value in IDLE. Only `grant_valid` qualifies it.

## Structure
- Package `rr_arb_pkg` holds:
  - `NUM_REQ`=8 and `IDX_W`=3.
  - A state typedef {IDLE, GRANT}.
  - The rotate-priority search function (first set bit at or after a start index, modulo 8).
- There is one sub-module: the existing `decoder_3X8`, used for the one-hot grant.

## Test plan
- Reset, then `req`=8'h01: all outputs are 0 during reset. One cycle after req, `grant`=8'h01, `grant_idx`=0, `grant_valid`=1.
- Rotation: `req`=8'hFF held, and each winner drops its bit 2 cycles after its grant and re-raises it in the idle cycle. Grants run in order 0,1,…,7,0, with one idle cycle between each.
- Wrap: after a grant to index 6 is released, `req`=8'b0100_0001. The next grant is index 0, not 6.
- Timeout with `MAX_HOLD`=4 and `req`=8'h03 held:
  - `grant`=8'h01 for exactly 4 cycles, then a `timeout` pulse.
  - One idle cycle, then `grant`=8'h02.
- No timeout with `MAX_HOLD`=4 and `req`=8'h04 held for 20 cycles: `grant`=8'h04 throughout and `timeout` stays 0.
- Async reset during a grant to index 5: outputs drop to 0 before the next `clk` edge. After release with `req`=8'h24, the grant goes to index 2.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and the rotate-priority search
// used by the eight-way round-robin arbiter.
package rr_arb_pkg;

   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned IDX_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // First set bit at or after start, wrapping modulo NUM_REQ; returns start
   // when req is empty (caller only uses the result when req != 0).
   function automatic logic [IDX_W-1:0] rr_search(
      input logic [NUM_REQ-1:0] req,
      input logic [IDX_W-1:0]   start
   );
      logic [IDX_W-1:0] w_idx;
      logic [IDX_W-1:0] w_found;
      logic             w_hit;
      w_found = start;
      w_hit   = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx = start + IDX_W'(k);
         if (!w_hit && req[w_idx]) begin
            w_found = w_idx;
            w_hit   = 1'b1;
         end
      end
      return w_found;
   endfunction

endpackage

// File: rtl/rr_arbiter_8_decoder.sv
// Existing 3-to-8 one-hot decoder; x is the most significant select bit.
module decoder_3X8 (
   input  logic       x,
   input  logic       y,
   input  logic       z,
   output logic [7:0] d
);

   always_comb begin
      d = 8'h01 << {x, y, z};
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with optional hold limit that forces
// rotation when the current owner keeps the grant while others wait.
module rr_arbiter_8
   import rr_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid,
   output logic               timeout
);

   localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam bit          HOLD_EN = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST =
      (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic [IDX_W-1:0]   r_last;
   logic [IDX_W-1:0]   w_last_nxt;
   logic [CNT_W-1:0]   r_hold;
   logic [CNT_W-1:0]   w_hold_nxt;
   logic               r_valid;
   logic               w_valid_nxt;
   logic               r_timeout;
   logic               w_timeout_nxt;
   logic [NUM_REQ-1:0] w_dec;
   logic               w_others;

   decoder_3X8 u_dec (
      .x (r_idx[2]),
      .y (r_idx[1]),
      .z (r_idx[0]),
      .d (w_dec)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_last_nxt    = r_last;
      w_hold_nxt    = r_hold;
      w_valid_nxt   = r_valid;
      w_timeout_nxt = 1'b0;
      w_others      = |(req & ~w_dec);

      unique case (r_state)
         IDLE: begin
            if (req != '0) begin
               w_idx_nxt   = rr_search(req, r_last + IDX_W'(1));
               w_valid_nxt = 1'b1;
               w_hold_nxt  = '0;
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (!req[r_idx]) begin
               w_valid_nxt = 1'b0;
               w_last_nxt  = r_idx;
               w_state_nxt = IDLE;
            end else if (HOLD_EN && r_hold == HOLD_LAST) begin
               // At the limit: rotate only if someone else is waiting,
               // otherwise keep the grant with the counter saturated.
               if (w_others) begin
                  w_timeout_nxt = 1'b1;
                  w_valid_nxt   = 1'b0;
                  w_last_nxt    = r_idx;
                  w_state_nxt   = IDLE;
               end
            end else if (HOLD_EN) begin
               w_hold_nxt = r_hold + CNT_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_last    <= '1;
         r_hold    <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_last    <= w_last_nxt;
         r_hold    <= w_hold_nxt;
         r_valid   <= w_valid_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   always_comb begin
      grant       = w_dec & {NUM_REQ{r_valid}};
      grant_idx   = r_idx;
      grant_valid = r_valid;
      timeout     = r_timeout;
   end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 (MAX_HOLD=4): vector table,
// hand-written corner sequences and random traffic against a reference model.
module tb_rr_arbiter_8;

   localparam int MH = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit m_busy;
   int m_idx;
   int m_last;
   int m_hold;
   bit m_to;

   rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] req;
      logic [7:0] grant;
      logic [2:0] idx;
      logic       valid;
      logic       to;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [7:0] eg, input logic [2:0] ei,
                             input logic ev, input logic et);
      check({name, ".grant"}, 32'(grant), 32'(eg));
      check({name, ".grant_idx"}, 32'(grant_idx), 32'(ei));
      check({name, ".grant_valid"}, 32'(grant_valid), 32'(ev));
      check({name, ".timeout"}, 32'(timeout), 32'(et));
   endtask

   task automatic model_reset();
      m_busy = 0; m_idx = 0; m_last = 7; m_hold = 0; m_to = 0;
   endtask

   // one clock of the arbitration rules, applied to the request seen at the edge
   task automatic model_step(input logic [7:0] r);
      int j;
      m_to = 0;
      if (!m_busy) begin
         if (r != 8'h00) begin
            for (int k = 1; k <= 8; k++) begin
               j = (m_last + k) % 8;
               if (r[j] && !m_busy) begin
                  m_idx = j; m_busy = 1; m_hold = 0;
               end
            end
         end
      end else if (!r[m_idx]) begin
         m_busy = 0; m_last = m_idx;
      end else if (m_hold == MH - 1) begin
         if ((r & ~(8'h01 << m_idx)) != 8'h00) begin
            m_to = 1; m_busy = 0; m_last = m_idx;
         end
      end else begin
         m_hold++;
      end
   endtask

   task automatic tick();
      model_step(req);
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string name);
      logic [7:0] eg;
      eg = m_busy ? (8'h01 << m_idx) : 8'h00;
      check_outs(name, eg, 3'(m_idx), m_busy, m_to);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
      vecs[1]  = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
      vecs[2]  = '{8'h80, 8'h80, 3'd7, 1'b1, 1'b0};
      vecs[3]  = '{8'h00, 8'h00, 3'd7, 1'b0, 1'b0};
      vecs[4]  = '{8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
      vecs[5]  = '{8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
      vecs[6]  = '{8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
      vecs[7]  = '{8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
      vecs[8]  = '{8'h03, 8'h00, 3'd0, 1'b0, 1'b1};
      vecs[9]  = '{8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
      vecs[10] = '{8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
      vecs[11] = '{8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
      vecs[12] = '{8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
      vecs[13] = '{8'h03, 8'h00, 3'd1, 1'b0, 1'b1};
      vecs[14] = '{8'h00, 8'h00, 3'd1, 1'b0, 1'b0};
      vecs[15] = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};

      do_reset();

      // first grant, parking at 7, then timeout rotation between 0 and 1
      for (int i = 0; i < 16; i++) begin
         req = vecs[i].req;
         tick();
         check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].idx, vecs[i].valid, vecs[i].to);
      end

      // lone requester keeps the grant past the hold limit, no timeout
      for (int i = 0; i < 20; i++) begin
         tick();
         check_outs($sformatf("hold%0d", i), 8'h04, 3'd2, 1'b1, 1'b0);
      end
      req = 8'h00;
      tick();
      check_outs("hold_rel", 8'h00, 3'd2, 1'b0, 1'b0);

      // rotation 0..7,0 with one idle cycle per handover
      do_reset();
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick();
         check_outs($sformatf("rot%0d", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
         tick();
         req[k % 8] = 1'b0;
         tick();
         check($sformatf("rot%0d_idle", k), 32'(grant_valid), 32'd0);
         req = 8'hFF;
      end
      req = 8'h00;
      tick();
      tick();

      // wrap: after 6 is released, 0 beats 6
      req = 8'h40;
      tick();
      check_outs("wrap_g6", 8'h40, 3'd6, 1'b1, 1'b0);
      req = 8'h00;
      tick();
      check("wrap_idle", 32'(grant_valid), 32'd0);
      req = 8'h41;
      tick();
      check_outs("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b0);
      req = 8'h00;
      tick();

      // async reset mid-grant to index 5
      req = 8'h20;
      tick();
      check_outs("ar_g5", 8'h20, 3'd5, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outs("ar_async", 8'h00, 3'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;
      req = 8'h24;
      tick();
      check_outs("ar_after", 8'h04, 3'd2, 1'b1, 1'b0);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) req = 8'($urandom);
            else req = 8'($urandom) & 8'($urandom);
         end
         tick();
         check_model($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
